tcp_reassembly_buffer: RTL and testbench



---
 rtl/tcp_reassembly_buffer_pkg.sv | 23 ++
 rtl/tcp_reassembly_buffer_if.sv | 12 +
 rtl/tcp_reassembly_buffer_out_reg.sv | 54 +++++
 rtl/tcp_reassembly_buffer.sv | 187 ++++++++++++++++++
 tb/tb_tcp_reassembly_buffer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_reassembly_buffer_pkg.sv
// Shared types and modulo-2^N sequence helpers for the TCP reassembly buffer.
package tcp_rb_pkg;

    localparam int unsigned RB_SEQ_BITS   = 32;
    localparam int unsigned RB_DATA_WIDTH = 8;

    typedef logic [RB_SEQ_BITS-1:0] seq_t;

    typedef struct packed {
        logic                     last;
        logic [RB_DATA_WIDTH-1:0] data;
    } slot_t;

    function automatic seq_t seq_diff(input seq_t a, input seq_t b);
        return a - b;
    endfunction

    // True when a lies in [base, base+depth) with wrap-around.
    function automatic logic seq_in_window(input seq_t a, input seq_t base, input seq_t depth);
        return seq_diff(a, base) < depth;
    endfunction

endpackage

// File: rtl/tcp_reassembly_buffer_if.sv
// AXI4-Stream byte channel used for both the segment input and the in-order output.
interface tcp_rb_axis_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/tcp_reassembly_buffer_out_reg.sv
// Single-entry AXI-Stream output register; holds data/last stable until tready.
module tcp_rb_out_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  can_load,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    output logic                  tlast,
    input  logic                  tready
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    assign can_load = !valid_q || tready;
    assign tdata    = data_q;
    assign tvalid   = valid_q;
    assign tlast    = last_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end else if (tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/tcp_reassembly_buffer.sv
// Byte-granular TCP receive reassembly buffer with cumulative ACK scanner and in-order drain.
// Optional SACK block tracking is built when TCP_RB_SACK_EN is defined.
module tcp_reassembly_buffer
    import tcp_rb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned SEQ_BITS   = 32,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tcp_rb_axis_if.slave         s_axis,
    input  logic [SEQ_BITS-1:0]  s_seq,
    tcp_rb_axis_if.master        m_axis,
    input  logic                 base_valid,
    input  logic [SEQ_BITS-1:0]  seq_base,
    output logic [SEQ_BITS-1:0]  ack_out,
    output logic                 ack_update,
    output logic [31:0]          window_size,
`ifdef TCP_RB_SACK_EN
    output logic                 sack_valid,
    output logic [SEQ_BITS-1:0]  sack_left,
    output logic [SEQ_BITS-1:0]  sack_right,
`endif
    output logic [CNT_BITS-1:0]  drop_cnt
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam seq_t        DEPTH_SEQ = seq_t'(DEPTH);

    logic                anchored_q, anchored_d;
    logic                first_q, first_d;
    seq_t                beat_seq_q, beat_seq_d;
    seq_t                rd_seq_q, rd_seq_d;
    seq_t                ack_q, ack_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic                adv_q, adv_d;
    logic [CNT_BITS-1:0] drop_q, drop_d;
    slot_t               mem_q [DEPTH];

    seq_t             beat_seq;
    logic             accept, wr_en, adv, drain, out_can_load;
    logic [IDX_W-1:0] wr_idx, rd_idx, ack_idx;
    slot_t            rd_slot;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic             m_tvalid, m_tlast;

    assign beat_seq = first_q ? seq_t'(s_seq) : beat_seq_q;
    assign accept   = s_axis.tvalid && anchored_q && !base_valid;
    assign wr_en    = accept && seq_in_window(beat_seq, rd_seq_q, DEPTH_SEQ);
    assign wr_idx   = beat_seq[IDX_W-1:0];
    assign rd_idx   = rd_seq_q[IDX_W-1:0];
    assign ack_idx  = ack_q[IDX_W-1:0];
    assign rd_slot  = mem_q[rd_idx];

    // Scanner stops at a hole or once a full window is acknowledged but undrained.
    assign adv   = anchored_q && valid_q[ack_idx] && seq_in_window(ack_q, rd_seq_q, DEPTH_SEQ);
    assign drain = anchored_q && !base_valid && (ack_q != rd_seq_q) && out_can_load;

    always_comb begin
        anchored_d = anchored_q;
        first_d    = first_q;
        beat_seq_d = beat_seq_q;
        rd_seq_d   = rd_seq_q;
        ack_d      = ack_q;
        valid_d    = valid_q;
        adv_d      = adv_q;
        drop_d     = drop_q;
        if (base_valid) begin
            anchored_d = 1'b1;
            first_d    = 1'b1;
            rd_seq_d   = seq_t'(seq_base);
            ack_d      = seq_t'(seq_base);
            valid_d    = '0;
            adv_d      = 1'b0;
        end else begin
            if (accept) begin
                beat_seq_d = beat_seq + seq_t'(1);
                first_d    = s_axis.tlast;
                if (!wr_en && drop_q != '1) drop_d = drop_q + 1'b1;
            end
            if (wr_en) valid_d[wr_idx] = 1'b1;
            // Drain clear comes last so a duplicate of the byte leaving cannot resurrect its slot.
            if (drain) begin
                valid_d[rd_idx] = 1'b0;
                rd_seq_d        = rd_seq_q + seq_t'(1);
            end
            if (adv) ack_d = ack_q + seq_t'(1);
            adv_d = adv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anchored_q <= 1'b0;
            first_q    <= 1'b1;
            beat_seq_q <= '0;
            rd_seq_q   <= '0;
            ack_q      <= '0;
            valid_q    <= '0;
            adv_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            anchored_q <= anchored_d;
            first_q    <= first_d;
            beat_seq_q <= beat_seq_d;
            rd_seq_q   <= rd_seq_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            adv_q      <= adv_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= '{last: s_axis.tlast, data: s_axis.tdata};
    end

    tcp_rb_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (base_valid),
        .load      (drain),
        .load_data (rd_slot.data),
        .load_last (rd_slot.last),
        .can_load  (out_can_load),
        .tdata     (m_tdata),
        .tvalid    (m_tvalid),
        .tlast     (m_tlast),
        .tready    (m_axis.tready)
    );

    assign m_axis.tdata  = m_tdata;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tlast  = m_tlast;
    assign s_axis.tready = anchored_q;

    assign ack_out     = ack_q;
    assign ack_update  = adv_q && !adv;
    assign window_size = 32'(DEPTH) - 32'(seq_diff(ack_q, rd_seq_q));
    assign drop_cnt    = drop_q;

`ifdef TCP_RB_SACK_EN
    localparam seq_t SEQ_HALF = {1'b1, {(RB_SEQ_BITS-1){1'b0}}};

    logic sack_valid_q, sack_valid_d;
    seq_t sack_left_q, sack_left_d;
    seq_t sack_right_q, sack_right_d;

    always_comb begin
        sack_valid_d = sack_valid_q;
        sack_left_d  = sack_left_q;
        sack_right_d = sack_right_q;
        if (base_valid) begin
            sack_valid_d = 1'b0;
        end else if (wr_en && beat_seq != ack_q) begin
            if (sack_valid_q && beat_seq == sack_right_q) begin
                sack_right_d = beat_seq + seq_t'(1);
            end else begin
                sack_valid_d = 1'b1;
                sack_left_d  = beat_seq;
                sack_right_d = beat_seq + seq_t'(1);
            end
        end else if (sack_valid_q && seq_diff(ack_q, sack_left_q) < SEQ_HALF) begin
            sack_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sack_valid_q <= 1'b0;
            sack_left_q  <= '0;
            sack_right_q <= '0;
        end else begin
            sack_valid_q <= sack_valid_d;
            sack_left_q  <= sack_left_d;
            sack_right_q <= sack_right_d;
        end
    end

    assign sack_valid = sack_valid_q;
    assign sack_left  = sack_left_q;
    assign sack_right = sack_right_q;
`endif

endmodule

// File: tb/tb_tcp_reassembly_buffer.sv
// Directed self-checking bench for tcp_reassembly_buffer (SACK checks built with TCP_RB_SACK_EN).
module tb_tcp_reassembly_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_seq;
    logic        base_valid;
    logic [31:0] seq_base;
    logic [31:0] ack_out;
    logic        ack_update;
    logic [31:0] window_size;
    logic [15:0] drop_cnt;
`ifdef TCP_RB_SACK_EN
    logic        sack_valid;
    logic [31:0] sack_left;
    logic [31:0] sack_right;
`endif

    tcp_rb_axis_if #(.DATA_WIDTH(8)) s_if ();
    tcp_rb_axis_if #(.DATA_WIDTH(8)) m_if ();

    tcp_reassembly_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (256),
        .SEQ_BITS   (32),
        .CNT_BITS   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis      (s_if),
        .s_seq       (s_seq),
        .m_axis      (m_if),
        .base_valid  (base_valid),
        .seq_base    (seq_base),
        .ack_out     (ack_out),
        .ack_update  (ack_update),
        .window_size (window_size),
`ifdef TCP_RB_SACK_EN
        .sack_valid  (sack_valid),
        .sack_left   (sack_left),
        .sack_right  (sack_right),
`endif
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int upd_cnt  = 0;
    logic [8:0] out_q [$];
    logic       stab_en = 1'b0;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat(input logic [31:0] s);
        return s[7:0] ^ 8'h5A;
    endfunction

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready) out_q.push_back({m_if.tlast, m_if.tdata});
        if (ack_update) upd_cnt++;
        if (stab_en && prev_v && !prev_r) begin
            check("stall_valid", 64'(m_if.tvalid), 64'd1);
            check("stall_data", 64'(m_if.tdata), 64'(prev_d));
        end
        prev_v = m_if.tvalid;
        prev_r = m_if.tready;
        prev_d = m_if.tdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic anchor(input logic [31:0] base);
        seq_base   = base;
        base_valid = 1'b1;
        tick(1);
        base_valid = 1'b0;
    endtask

    task automatic send_seg(input logic [31:0] seq, input int len);
        for (int i = 0; i < len; i++) begin
            s_seq         = seq;
            s_if.tdata    = pat(seq + 32'(i));
            s_if.tlast    = (i == len - 1);
            s_if.tvalid   = 1'b1;
            tick(1);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n, input string tag);
        int cyc = 0;
        while (out_q.size() < n && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        if (out_q.size() < n) check({tag, "_timeout"}, 64'(out_q.size()), 64'(n));
    endtask

    // Pops n bytes and compares against seq order; tlast marks every seg_len-th byte.
    task automatic check_stream(input logic [31:0] base, input int n, input int seg_len, input string tag);
        logic [8:0] item;
        for (int i = 0; i < n; i++) begin
            if (out_q.size() == 0) break;
            item = out_q.pop_front();
            check(tag, 64'(item), 64'({((i + 1) % seg_len == 0), pat(base + 32'(i))}));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        s_seq       = '0;
        base_valid  = 1'b0;
        seq_base    = '0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        tick(3);
        check("rst_ack", 64'(ack_out), 64'd0);
        check("rst_window", 64'(window_size), 64'd256);
        check("rst_tready", 64'(s_if.tready), 64'd0);
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_ackupd", 64'(ack_update), 64'd0);
        rst_n = 1'b1;
        tick(2);
        check("pre_anchor_tready", 64'(s_if.tready), 64'd0);

        // In-order segment
        m_if.tready = 1'b1;
        anchor(32'd1000);
        check("anchor_tready", 64'(s_if.tready), 64'd1);
        check("anchor_ack", 64'(ack_out), 64'd1000);
        upd_cnt = 0;
        send_seg(32'd1000, 10);
        wait_out(10, "inorder");
        tick(3);
        check("inorder_ack", 64'(ack_out), 64'd1010);
        check("inorder_updates", 64'(upd_cnt), 64'd1);
        check("inorder_window", 64'(window_size), 64'd256);
        check_stream(32'd1000, 10, 10, "inorder_data");

        // Out-of-order: later half first
        anchor(32'd1000);
        send_seg(32'd1005, 5);
        tick(5);
        check("ooo_no_output", 64'(out_q.size()), 64'd0);
        check("ooo_ack_hold", 64'(ack_out), 64'd1000);
        check("ooo_window", 64'(window_size), 64'd256);
        send_seg(32'd1000, 5);
        wait_out(10, "ooo");
        tick(3);
        check("ooo_ack", 64'(ack_out), 64'd1010);
        check_stream(32'd1000, 10, 5, "ooo_data");

        // Window edge; the output register parks one byte, so DEPTH+1 bytes fit
        m_if.tready = 1'b0;
        anchor(32'd0);
        send_seg(32'd0, 257);
        tick(5);
        check("full_window", 64'(window_size), 64'd0);
        check("full_ack", 64'(ack_out), 64'd257);
        check("full_drop0", 64'(drop_cnt), 64'd0);
        send_seg(32'd257, 1);
        tick(2);
        check("full_drop1", 64'(drop_cnt), 64'd1);
        check("full_tready", 64'(s_if.tready), 64'd1);
        check("full_window2", 64'(window_size), 64'd0);
        m_if.tready = 1'b1;
        wait_out(257, "full");
        tick(3);
        check("full_drained_window", 64'(window_size), 64'd256);
        check("full_extra", 64'(out_q.size()), 64'd257);
        check_stream(32'd0, 257, 257, "full_data");

        // Sequence wrap
        anchor(32'hFFFF_FFFC);
        send_seg(32'hFFFF_FFFC, 8);
        wait_out(8, "wrap");
        tick(3);
        check("wrap_ack", 64'(ack_out), 64'h0000_0004);
        check_stream(32'hFFFF_FFFC, 8, 8, "wrap_data");

        // Backpressure toggling every 2 cycles
        anchor(32'd2000);
        stab_en = 1'b1;
        fork
            send_seg(32'd2000, 20);
            for (int c = 0; c < 80; c++) begin
                m_if.tready = c[1];
                tick(1);
            end
        join
        m_if.tready = 1'b1;
        wait_out(20, "bp");
        tick(3);
        stab_en = 1'b0;
        check("bp_count", 64'(out_q.size()), 64'd20);
        check_stream(32'd2000, 20, 20, "bp_data");

        // Re-anchor while a byte is pending on the output
        m_if.tready = 1'b0;
        anchor(32'd3000);
        send_seg(32'd3000, 6);
        tick(4);
        check("reanchor_pending", 64'(m_if.tvalid), 64'd1);
        anchor(32'd4000);
        check("reanchor_tvalid", 64'(m_if.tvalid), 64'd0);
        check("reanchor_ack", 64'(ack_out), 64'd4000);
        check("reanchor_window", 64'(window_size), 64'd256);
        m_if.tready = 1'b1;
        tick(10);
        check("reanchor_stale", 64'(out_q.size()), 64'd0);
        send_seg(32'd4000, 3);
        wait_out(3, "reanchor");
        check_stream(32'd4000, 3, 3, "reanchor_data");
        check("drop_hold", 64'(drop_cnt), 64'd1);

`ifdef TCP_RB_SACK_EN
        anchor(32'd1000);
        send_seg(32'd1005, 3);
        tick(2);
        check("sack_valid", 64'(sack_valid), 64'd1);
        check("sack_left", 64'(sack_left), 64'd1005);
        check("sack_right", 64'(sack_right), 64'd1008);
        send_seg(32'd1000, 5);
        wait_out(8, "sack");
        tick(3);
        check("sack_cleared", 64'(sack_valid), 64'd0);
        out_q.delete();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
